// File: rtl/oled_frame_reader_if.sv
// Bundle of the frame-reader signals that connect it to the OLED driver and
// to the frame-buffer read port. The master modport is the reader's view.
interface oled_frame_reader_if #(
  parameter int unsigned ADDR_W = 13
) ();

  logic              resync;
  logic              next_pixel;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic [15:0]       color;
  logic              color_valid;
  logic [6:0]        pix_x;
  logic [5:0]        pix_y;
  logic              sof;
  logic [7:0]        frame_cnt;
  logic              underrun;

  modport master (
    input  resync, next_pixel, rd_data,
    output rd_addr, color, color_valid, pix_x, pix_y, sof, frame_cnt, underrun
  );

  modport slave (
    output resync, next_pixel, rd_data,
    input  rd_addr, color, color_valid, pix_x, pix_y, sof, frame_cnt, underrun
  );

endinterface

// File: rtl/oled_frame_reader.sv
// Walks the OLED raster in step with the driver's next_pixel strobe, reads the
// captured image from the frame buffer for pixels inside the image window and
// presents a held RGB565 colour; pixels outside the window get a border colour.
module oled_frame_reader #(
  parameter int unsigned IMG_COLS     = 80,
  parameter int unsigned IMG_ROWS     = 60,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned OLED_COLS    = 96,
  parameter int unsigned OLED_ROWS    = 64,
  parameter int unsigned X_OFF        = 8,
  parameter int unsigned Y_OFF        = 2,
  parameter int unsigned RD_LAT       = 1,
  parameter logic [15:0] BORDER_COLOR = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  oled_frame_reader_if.master bus
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {StFetch, StWait, StLatch, StReady} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic [6:0]        pix_x_q, pix_x_d;
  logic [5:0]        pix_y_q, pix_y_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       color_q, color_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic [7:0]        frame_q, frame_d;
  logic              underrun_q, underrun_d;
  logic              border_q, border_d;

  logic              in_window;
  logic [ADDR_W-1:0] win_addr;
  logic [15:0]       conv_color;
  logic              unused_rd_lsb;

  assign in_window = (pix_x_q >= 7'(X_OFF)) && (pix_x_q < 7'(X_OFF + IMG_COLS)) &&
                     (pix_y_q >= 6'(Y_OFF)) && (pix_y_q < 6'(Y_OFF + IMG_ROWS));

  // Only meaningful while in_window, so the offset subtractions never wrap.
  assign win_addr = ADDR_W'(pix_y_q - 6'(Y_OFF)) * ADDR_W'(IMG_COLS) +
                    ADDR_W'(pix_x_q - 7'(X_OFF));

  // Buffer word is r5/g5/b6; green widens by MSB replication, blue drops its LSB.
  assign conv_color    = {bus.rd_data[15:11], bus.rd_data[10:6], bus.rd_data[10],
                          bus.rd_data[5:1]};
  assign unused_rd_lsb = bus.rd_data[0];

  // Next-state: resync beats next_pixel, next_pixel beats the fetch sequence.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    rd_addr_d  = rd_addr_q;
    color_d    = color_q;
    valid_d    = valid_q;
    sof_d      = 1'b0;
    frame_d    = frame_q;
    underrun_d = underrun_q;
    border_d   = border_q;

    if (bus.resync) begin
      pix_x_d = '0;
      pix_y_d = '0;
      state_d = StFetch;
      valid_d = 1'b0;
      wait_d  = '0;
    end else if (bus.next_pixel) begin
      // Consuming before the colour is ready aborts the fetch in flight.
      if (state_q != StReady) begin
        underrun_d = 1'b1;
      end
      if (pix_x_q == 7'(OLED_COLS - 1)) begin
        pix_x_d = '0;
        if (pix_y_q == 6'(OLED_ROWS - 1)) begin
          pix_y_d = '0;
          sof_d   = 1'b1;
          frame_d = frame_q + 8'd1;
        end else begin
          pix_y_d = pix_y_q + 6'd1;
        end
      end else begin
        pix_x_d = pix_x_q + 7'd1;
      end
      state_d = StFetch;
      valid_d = 1'b0;
      wait_d  = '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (in_window) begin
            rd_addr_d = win_addr;
          end
          border_d = ~in_window;
          wait_d   = '0;
          state_d  = StWait;
        end
        StWait: begin
          if (wait_q == CntW'(RD_LAT - 1)) begin
            state_d = StLatch;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        StLatch: begin
          color_d = border_q ? BORDER_COLOR : conv_color;
          valid_d = 1'b1;
          state_d = StReady;
        end
        default: begin
          state_d = StReady;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      wait_q     <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      rd_addr_q  <= '0;
      color_q    <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      frame_q    <= '0;
      underrun_q <= 1'b0;
      border_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      rd_addr_q  <= rd_addr_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
      border_q   <= border_d;
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.color       = color_q;
  assign bus.color_valid = valid_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.sof         = sof_q;
  assign bus.frame_cnt   = frame_q;
  assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_oled_frame_reader.sv
// Directed bench for oled_frame_reader: inputs change and outputs are sampled
// on the falling clock edge.
module tb_oled_frame_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oled_frame_reader_if #(.ADDR_W(13)) bus ();

  oled_frame_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int n_timeouts = 0;
  int sof_total  = 0;
  int sof_base   = 0;

  always @(negedge clk) if (bus.sof === 1'b1) sof_total++;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic pulse();
    bus.next_pixel = 1'b1;
    @(negedge clk);
    bus.next_pixel = 1'b0;
  endtask

  task automatic hold_next(input int n);
    bus.next_pixel = 1'b1;
    repeat (n) @(negedge clk);
    bus.next_pixel = 1'b0;
  endtask

  // Bounded wait for color_valid; a stall is tallied and checked later.
  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (bus.color_valid === 1'b1) return;
      @(negedge clk);
    end
    n_timeouts++;
  endtask

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      wait_ready();
      pulse();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.resync = 1'b0;
    bus.next_pixel = 1'b0;
    bus.rd_data = 16'h0000;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.rd_addr, bus.color, bus.color_valid, bus.sof,
         bus.frame_cnt, bus.underrun} !== 53'd0) begin
      n_fail++;
      $display("FAIL reset_state: got x=%0d y=%0d addr=%0d col=%h v=%b sof=%b fc=%0d ur=%b want all 0",
               bus.pix_x, bus.pix_y, bus.rd_addr, bus.color, bus.color_valid, bus.sof,
               bus.frame_cnt, bus.underrun);
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.color_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL reset_valid_cycle%0d: got %b want %b", i, bus.color_valid, i == 3);
      end
    end
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.color, bus.underrun} !== {7'd0, 6'd0, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_pixel: got (%0d,%0d) col=%h ur=%b want (0,0) col=0000 ur=0",
               bus.pix_x, bus.pix_y, bus.color, bus.underrun);
    end
  endtask

  task automatic test_window_start();
    sof_base = sof_total;
    bus.rd_data = 16'h8420;
    consume(200);
    wait_ready();
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.rd_addr, bus.color} !== {7'd8, 6'd2, 13'd0, 16'h8430}) begin
      n_fail++;
      $display("FAIL win_first: got (%0d,%0d) addr=%0d col=%h want (8,2) addr=0 col=8430",
               bus.pix_x, bus.pix_y, bus.rd_addr, bus.color);
    end
    bus.rd_data = 16'hFFFF;
    consume(1);
    wait_ready();
    n_checks++;
    if ({bus.rd_addr, bus.color} !== {13'd1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL win_white: got addr=%0d col=%h want addr=1 col=ffff", bus.rd_addr, bus.color);
    end
  endtask

  task automatic test_window_edge();
    bus.rd_data = 16'h1235;
    consume(5742);
    wait_ready();
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.rd_addr, bus.color} !== {7'd87, 6'd61, 13'd4799, 16'h121A})
    begin
      n_fail++;
      $display("FAIL win_last: got (%0d,%0d) addr=%0d col=%h want (87,61) addr=4799 col=121a",
               bus.pix_x, bus.pix_y, bus.rd_addr, bus.color);
    end
    bus.rd_data = 16'hFFFF;
    consume(1);
    wait_ready();
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.rd_addr, bus.color} !== {7'd88, 6'd61, 13'd4799, 16'h0000})
    begin
      n_fail++;
      $display("FAIL win_border: got (%0d,%0d) addr=%0d col=%h want (88,61) addr=4799 col=0000",
               bus.pix_x, bus.pix_y, bus.rd_addr, bus.color);
    end
  endtask

  task automatic test_frame_wrap();
    consume(199);
    wait_ready();
    n_checks++;
    if ({bus.pix_x, bus.pix_y} !== {7'd95, 6'd63}) begin
      n_fail++;
      $display("FAIL wrap_last: got (%0d,%0d) want (95,63)", bus.pix_x, bus.pix_y);
    end
    pulse();
    n_checks++;
    if ({bus.sof, bus.pix_x, bus.pix_y, bus.frame_cnt} !== {1'b1, 7'd0, 6'd0, 8'd1}) begin
      n_fail++;
      $display("FAIL wrap_sof: got sof=%b (%0d,%0d) fc=%0d want sof=1 (0,0) fc=1",
               bus.sof, bus.pix_x, bus.pix_y, bus.frame_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.sof !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_sof_width: got %b want 0", bus.sof);
    end
    n_checks++;
    if ({sof_total - sof_base, bus.underrun} !== {32'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_sof_count: got sofs=%0d ur=%b want sofs=1 ur=0",
               sof_total - sof_base, bus.underrun);
    end
  endtask

  task automatic test_underrun();
    wait_ready();
    pulse();
    @(negedge clk);
    bus.next_pixel = 1'b1;
    @(negedge clk);
    bus.next_pixel = 1'b0;
    n_checks++;
    if ({bus.underrun, bus.pix_x, bus.pix_y, bus.color_valid} !== {1'b1, 7'd2, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL underrun_set: got ur=%b (%0d,%0d) v=%b want ur=1 (2,0) v=0",
               bus.underrun, bus.pix_x, bus.pix_y, bus.color_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.color_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL underrun_valid_cycle%0d: got %b want %b", i, bus.color_valid, i == 3);
      end
    end
    consume(1);
    wait_ready();
    n_checks++;
    if ({bus.underrun, bus.pix_x, bus.color} !== {1'b1, 7'd3, 16'h0000}) begin
      n_fail++;
      $display("FAIL underrun_sticky: got ur=%b x=%0d col=%h want ur=1 x=3 col=0000",
               bus.underrun, bus.pix_x, bus.color);
    end
  endtask

  task automatic test_fast_frames();
    sof_base = sof_total;
    hold_next(2 * 6144);
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.frame_cnt, bus.underrun} !== {7'd3, 6'd0, 8'd3, 1'b1} ||
        sof_total - sof_base != 2) begin
      n_fail++;
      $display("FAIL fast_frames: got (%0d,%0d) fc=%0d ur=%b sofs=%0d want (3,0) fc=3 ur=1 sofs=2",
               bus.pix_x, bus.pix_y, bus.frame_cnt, bus.underrun, sof_total - sof_base);
    end
  endtask

  task automatic test_resync();
    hold_next(997);
    wait_ready();
    n_checks++;
    if ({bus.pix_x, bus.pix_y} !== {7'd40, 6'd10}) begin
      n_fail++;
      $display("FAIL resync_pos: got (%0d,%0d) want (40,10)", bus.pix_x, bus.pix_y);
    end
    sof_base = sof_total;
    bus.resync = 1'b1;
    bus.next_pixel = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
    bus.next_pixel = 1'b0;
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.frame_cnt, bus.underrun, bus.color_valid} !==
        {7'd0, 6'd0, 8'd3, 1'b1, 1'b0} || sof_total != sof_base) begin
      n_fail++;
      $display("FAIL resync_apply: got (%0d,%0d) fc=%0d ur=%b v=%b sofs=%0d want (0,0) fc=3 ur=1 v=0 sofs=0",
               bus.pix_x, bus.pix_y, bus.frame_cnt, bus.underrun, bus.color_valid,
               sof_total - sof_base);
    end
    wait_ready();
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.color_valid} !== {7'd0, 6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL resync_ready: got (%0d,%0d) v=%b want (0,0) v=1",
               bus.pix_x, bus.pix_y, bus.color_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    bus.rd_data = 16'hFFFF;
    hold_next(201);
    wait_ready();
    n_checks++;
    if ({bus.rd_addr, bus.color} !== {13'd1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL rstwait_pre: got addr=%0d col=%h want addr=1 col=ffff", bus.rd_addr, bus.color);
    end
    pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.rd_addr, bus.color, bus.color_valid, bus.sof,
         bus.frame_cnt, bus.underrun} !== 53'd0) begin
      n_fail++;
      $display("FAIL rstwait_state: got x=%0d y=%0d addr=%0d col=%h v=%b sof=%b fc=%0d ur=%b want all 0",
               bus.pix_x, bus.pix_y, bus.rd_addr, bus.color, bus.color_valid, bus.sof,
               bus.frame_cnt, bus.underrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_resync_drops_next();
    wait_ready();
    pulse();
    bus.resync = 1'b1;
    bus.next_pixel = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
    bus.next_pixel = 1'b0;
    n_checks++;
    if ({bus.underrun, bus.pix_x, bus.pix_y} !== {1'b0, 7'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL resync_drop: got ur=%b (%0d,%0d) want ur=0 (0,0)",
               bus.underrun, bus.pix_x, bus.pix_y);
    end
  endtask

  task automatic test_no_stalls();
    n_checks++;
    if (n_timeouts !== 0) begin
      n_fail++;
      $display("FAIL ready_timeouts: got %0d want 0", n_timeouts);
    end
  endtask

  initial begin
    test_reset();
    test_window_start();
    test_window_edge();
    test_frame_wrap();
    test_underrun();
    test_fast_frames();
    test_resync();
    test_reset_in_wait();
    test_resync_drops_next();
    test_no_stalls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
